// File: rtl/cell_pkg.sv
// Shared definitions for the cell arbiter: default widths and the arbitration FSM encoding.
// Latency: none, definitions only.
// Backpressure: not applicable.
package cell_pkg;

    localparam int DEF_MSB  = 31;
    localparam int DEF_NREQ = 4;

    typedef enum logic [0:0] {
        ARB      = 1'b0,
        CFG_FAIR = 1'b1
    } arb_state_e;

endpackage

// File: rtl/cell_arbiter_if.sv
// Requester, config and response bundle between the clients and the cell arbiter.
// Latency: none, wiring only.
// Backpressure: req_ready/cfg_ready come back from the arbiter; responses cannot be stalled.
interface cell_arbiter_if
    import cell_pkg::*;
#(
    parameter int MSB  = DEF_MSB,
    parameter int NREQ = DEF_NREQ
) ();

    logic [NREQ*(MSB+1)-1:0] req_data;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [MSB:0]            cfg_param;
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [MSB:0]            resp_data;
    logic [NREQ-1:0]         resp_valid;

    modport master (
        output req_data, req_valid, cfg_param, cfg_valid,
        input  req_ready, cfg_ready, resp_data, resp_valid
    );

    modport slave (
        input  req_data, req_valid, cfg_param, cfg_valid,
        output req_ready, cfg_ready, resp_data, resp_valid
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request strictly after ptr, wrapping, as a one-hot grant.
// Latency: combinational.
// Backpressure: none; an all-zero request vector yields an all-zero grant.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        // k = NREQ lands back on ptr itself, so the last winner gets lowest priority
        for (int k = 1; k <= NREQ; k++) begin
            idx = PW'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cell_arbiter.sv
// Shares one compute cell between NREQ data requesters and a config port, one op per cycle.
// Latency: issue 1 cycle after handshake, resp_valid 3 cycles after handshake.
// Backpressure: combinational ready per cycle; config yields to pending data after every accept.
module cell_arbiter
    import cell_pkg::*;
#(
    parameter int MSB  = DEF_MSB,
    parameter int NREQ = DEF_NREQ
) (
    input  logic          clk,
    input  logic          rst_n,
    cell_arbiter_if.slave bus,
    output logic [MSB:0]  cell_data,
    output logic          cell_data_en,
    output logic [MSB:0]  cell_param,
    output logic          cell_param_en,
    input  logic [MSB:0]  cell_data_out,
    input  logic          cell_data_en_out,
    output logic          err
);

    localparam int W  = MSB + 1;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e      state, state_nxt;
    logic [PW-1:0]   rr_ptr;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] req_ready_c;
    logic            cfg_ready_c;
    logic            data_fire;
    logic            cfg_fire;
    logic [PW-1:0]   grant_idx;
    logic [MSB:0]    grant_word;
    logic [PW-1:0]   issue_idx;
    logic [PW-1:0]   tag;
    logic            tag_valid;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    always_comb begin
        state_nxt   = ARB;
        cfg_ready_c = 1'b0;
        req_ready_c = '0;
        case (state)
            ARB: begin
                if (bus.cfg_valid) begin
                    cfg_ready_c = 1'b1;
                    state_nxt   = CFG_FAIR;
                end else begin
                    req_ready_c = grant;
                end
            end
            CFG_FAIR: begin
                req_ready_c = grant;
                state_nxt   = ARB;
            end
            default: state_nxt = ARB;
        endcase
    end

    // Readies are combinational, so they are forced low while reset is held
    assign bus.req_ready = req_ready_c & {NREQ{rst_n}};
    assign bus.cfg_ready = cfg_ready_c & rst_n;
    assign data_fire     = |bus.req_ready;
    assign cfg_fire      = bus.cfg_ready;

    always_comb begin
        grant_idx  = '0;
        grant_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_idx  = PW'(i);
                grant_word = bus.req_data[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ARB;
            rr_ptr        <= PW'(NREQ - 1);
            cell_data     <= '0;
            cell_data_en  <= 1'b0;
            cell_param    <= '0;
            cell_param_en <= 1'b0;
            issue_idx     <= '0;
        end else begin
            state         <= state_nxt;
            cell_data_en  <= data_fire;
            cell_param_en <= cfg_fire;
            if (data_fire) begin
                rr_ptr    <= grant_idx;
                cell_data <= grant_word;
                issue_idx <= grant_idx;
            end
            if (cfg_fire) begin
                cell_param <= bus.cfg_param;
            end
        end
    end

    // Tag lines up with the cell's one-cycle compute delay
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid      <= 1'b0;
            tag            <= '0;
            bus.resp_data  <= '0;
            bus.resp_valid <= '0;
            err            <= 1'b0;
        end else begin
            tag_valid <= cell_data_en;
            tag       <= issue_idx;
            if (cell_data_en_out && tag_valid) begin
                bus.resp_data  <= cell_data_out;
                bus.resp_valid <= NREQ'(1) << tag;
            end else begin
                bus.resp_valid <= '0;
            end
            if (cell_data_en_out != tag_valid) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/cell_arbiter.md
CELL_ARBITER -- requirements
Module: cell_arbiter

Interface
REQ-001 Parameter MSB, default 31: data word is MSB+1 bits.
REQ-002 Parameter NREQ, default 4: number of data requesters, 2..8.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req_data  input  NREQ*(MSB+1)  per-requester data word; slot i occupies bits [i*(MSB+1) +: MSB+1].
REQ-006 req_valid  input  NREQ  per-requester offer.
REQ-007 req_ready  output  NREQ  per-requester accept, at most one bit set; a transfer occurs when valid&ready.
REQ-008 cfg_param  input  MSB+1  new trigger threshold for the shared cell.
REQ-009 cfg_valid / cfg_ready  input / output  1  config handshake.
REQ-010 cell_data / cell_data_en  output  MSB+1 / 1  to cell data_in / data_en.
REQ-011 cell_param / cell_param_en  output  MSB+1 / 1  to cell param_in / param_en.
REQ-012 cell_data_out / cell_data_en_out  input  MSB+1 / 1  from cell; result is 1 cycle after issue.
REQ-013 resp_data  output  MSB+1  registered copy of cell_data_out.
REQ-014 resp_valid  output  NREQ  one-hot pulse identifying the requester owning resp_data.
REQ-015 err  output  1  sticky protocol-error flag.

Function
REQ-016 Per cycle, issue at most one operation: a config (cell_param_en=1) or a data word (cell_data_en=1), never both.
REQ-017 cell_param_en and cell_data_en, with their words, SHALL be registered outputs asserted for exactly the cycle after the accepting handshake.
REQ-018 Arbitration FSM states: ARB, CFG_FAIR.
REQ-019 In ARB: if cfg_valid, assert cfg_ready and accept config; go to CFG_FAIR. Else grant a data requester by round-robin.
REQ-020 In CFG_FAIR: if any req_valid, grant round-robin data with cfg_ready=0; in all cases return to ARB next cycle.
REQ-021 Round-robin: search starts at the index after the last granted requester, wrapping NREQ-1 to 0; pointer advances only on an actual grant.
REQ-022 req_ready/cfg_ready are combinational from valids and state; no ready asserted when its valid is low.
REQ-023 Each data issue pushes the granted index into a 1-deep tag register with tag_valid=1; cleared when no data is issued.
REQ-024 On cell_data_en_out=1 with tag_valid=1: next cycle resp_data=cell_data_out and resp_valid=one-hot(tag).
REQ-025 On cell_data_en_out=1 with tag_valid=0, or cell_data_en_out=0 with tag_valid=1: set err; err cleared only by reset.
REQ-026 Back-to-back issue every cycle supported; throughput 1 op/cycle; data latency request handshake to resp_valid = 3 cycles.
REQ-027 Config issued cycle N takes effect for data issued cycle N+1 or later; no config is dropped or merged.

Reset
REQ-028 While rst_n=0: FSM=ARB, RR pointer=NREQ-1 (so requester 0 has first priority), tag_valid=0.
REQ-029 While rst_n=0: all outputs 0 (ready, enables, words, resp_valid, err).
REQ-030 Reset mid-operation discards the in-flight tag; no resp_valid after reset release for pre-reset issues.

Structure
REQ-031 Shared package cell_pkg: default MSB, default NREQ, FSM state enum.
REQ-032 One sub-module rr_arbiter (NREQ request vector, pointer in, one-hot grant out, combinational).
REQ-033 Implementation 120-400 RTL lines; no memories.

Verification
REQ-034 Reset, then req_valid=4'b0001, data 0x5 -> cycle+1 cell_data_en=1, cell_data=0x5; cycle+3 resp_valid=4'b0001 with cell model output.
REQ-035 req_valid=4'b1111 held 8 cycles -> grants 0,1,2,3,0,1,2,3; resp_valid order identical.
REQ-036 cfg_valid=1 and req_valid=4'b0011 held -> grants alternate cfg, r0, cfg, r1; never two cfg in a row while data pending.
REQ-037 cfg 0x20 issued then data 0x18 from r2 -> cell returns data_lo for r2 (0x18 <= 0x20); prior threshold 0x10 gives data_hi.
REQ-038 Force cell_data_en_out=1 with no issue -> err=1 next cycle, stays 1 until rst_n=0.
REQ-039 Assert rst_n=0 one cycle after issuing r1 -> all outputs 0, no resp_valid after release, next grant goes to r0.
